// File: rtl/adc_sar_array_ctrl_if.sv
// Purpose : control bundle between the SAR engine and the 16x32 capacitor array.
// Latency : n/a (signal bundle only).
// Backpressure: none; the array consumes every control line each cycle.
// Ports   : start/comp_in into the engine; sample/sw pairs, row/col decode,
//           en_bit_n, en_C0_n, result/valid/busy out of the engine.
//           master = SAR engine side, slave = array / requester side.
interface adc_sar_array_ctrl_if;
    logic        start;
    logic        comp_in;
    logic        sample;
    logic        sample_n;
    logic        sw;
    logic        sw_n;
    logic [15:0] row_n;
    logic [15:0] rowon_n;
    logic [15:0] rowoff_n;
    logic [31:0] col;
    logic [31:0] col_n;
    logic [2:0]  en_bit_n;
    logic        en_C0_n;
    logic [11:0] result;
    logic        valid;
    logic        busy;

    modport master (
        input  start, comp_in,
        output sample, sample_n, sw, sw_n,
        output row_n, rowon_n, rowoff_n, col, col_n,
        output en_bit_n, en_C0_n, result, valid, busy
    );

    modport slave (
        output start, comp_in,
        input  sample, sample_n, sw, sw_n,
        input  row_n, rowon_n, rowoff_n, col, col_n,
        input  en_bit_n, en_C0_n, result, valid, busy
    );
endinterface

// File: rtl/adc_sar_array_ctrl.sv
// Purpose : 12-bit SAR control engine driving a 16x32 thermometer unit-cell array + 3 binary caps.
// Latency : valid rises SAMPLE_CYCLES + 12*SETTLE_CYCLES + 1 cycles after start is taken (+1 with HOLD).
// Backpressure: none; start is only honoured in IDLE, ignored while busy.
// Ports   : clk, rst_n (async active-low); bus = adc_sar_array_ctrl_if.master
//           (start, comp_in in; sample/sw pairs, row/col decode, en_bit_n, en_C0_n,
//           result, valid, busy out). Every output comes straight from a flop.
// Option  : define SAR_NONOVL_EN to insert a one-cycle HOLD between SAMPLE and CONV.
module adc_sar_array_ctrl #(
    parameter int SAMPLE_CYCLES = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input logic                  clk,
    input logic                  rst_n,
    adc_sar_array_ctrl_if.master bus
);

    localparam logic [7:0] SAMPLE_LAST = 8'(SAMPLE_CYCLES - 1);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_HOLD,
        ST_CONV,
        ST_DONE
    } state_t;

    // Row decode: the row addressed by code[11:8] is the partial row,
    // rows below it are fully on, rows above it fully off.
    function automatic logic [15:0] dec_row_n(input logic [11:0] code);
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[i] = (4'(i) != code[11:8]);
        return v;
    endfunction

    function automatic logic [15:0] dec_rowon_n(input logic [11:0] code);
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[i] = !(4'(i) < code[11:8]);
        return v;
    endfunction

    function automatic logic [15:0] dec_rowoff_n(input logic [11:0] code);
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[i] = !(4'(i) > code[11:8]);
        return v;
    endfunction

    // Columns inside the partial row: the low code[7:3] cells are on.
    function automatic logic [31:0] dec_col(input logic [11:0] code);
        logic [31:0] v;
        for (int j = 0; j < 32; j++) v[j] = (5'(j) < code[7:3]);
        return v;
    endfunction

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [3:0]  r_bit;
    logic [11:0] r_code;
    logic [11:0] r_result;
    logic        r_valid;
    logic        r_busy;
    logic        r_sample;
    logic        r_sample_n;
    logic        r_sw;
    logic        r_sw_n;
    logic        r_en_c0_n;
    logic [2:0]  r_en_bit_n;
    logic [15:0] r_row_n;
    logic [15:0] r_rowon_n;
    logic [15:0] r_rowoff_n;
    logic [31:0] r_col;
    logic [31:0] r_col_n;

    state_t      w_state_nxt;
    logic [7:0]  w_cnt_nxt;
    logic [3:0]  w_bit_nxt;
    logic [11:0] w_code_nxt;
    logic [11:0] w_result_nxt;
    logic        w_valid_nxt;
    logic [11:0] w_trial;
    logic [31:0] w_col_nxt;

    // Next-state / next-code; outputs are decoded from the next code so the
    // array lines change on the same edge as the state.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_bit_nxt    = r_bit;
        w_code_nxt   = r_code;
        w_result_nxt = r_result;
        w_valid_nxt  = 1'b0;
        w_trial      = r_code;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = ST_SAMPLE;
                    w_cnt_nxt   = '0;
                    w_code_nxt  = '0;
                end
            end
            ST_SAMPLE: begin
                w_code_nxt = '0;
                if (r_cnt == SAMPLE_LAST) begin
                    w_cnt_nxt = '0;
`ifdef SAR_NONOVL_EN
                    w_state_nxt = ST_HOLD;
`else
                    w_state_nxt = ST_CONV;
                    w_bit_nxt   = 4'd11;
                    w_code_nxt  = 12'h800;
`endif
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            ST_HOLD: begin
                // Top plate already open; bottom plates leave vcm on the next edge.
                w_state_nxt = ST_CONV;
                w_cnt_nxt   = '0;
                w_bit_nxt   = 4'd11;
                w_code_nxt  = 12'h800;
            end
            ST_CONV: begin
                if (r_cnt == SETTLE_LAST) begin
                    w_cnt_nxt        = '0;
                    w_trial[r_bit]   = bus.comp_in;
                    if (r_bit != 4'd0) begin
                        w_trial[r_bit - 4'd1] = 1'b1;
                        w_bit_nxt             = r_bit - 4'd1;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                    w_code_nxt = w_trial;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            ST_DONE: begin
                // Result and valid land on the edge that leaves DONE.
                w_state_nxt  = ST_IDLE;
                w_result_nxt = r_code;
                w_valid_nxt  = 1'b1;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_col_nxt = dec_col(w_code_nxt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_code     <= '0;
            r_result   <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_sample   <= 1'b0;
            r_sample_n <= 1'b1;
            r_sw       <= 1'b0;
            r_sw_n     <= 1'b1;
            r_en_c0_n  <= 1'b1;
            r_en_bit_n <= 3'b111;
            r_row_n    <= 16'hFFFE;
            r_rowon_n  <= 16'hFFFF;
            r_rowoff_n <= 16'h0001;
            r_col      <= '0;
            r_col_n    <= '1;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_bit      <= w_bit_nxt;
            r_code     <= w_code_nxt;
            r_result   <= w_result_nxt;
            r_valid    <= w_valid_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_sample   <= (w_state_nxt == ST_SAMPLE);
            r_sample_n <= (w_state_nxt != ST_SAMPLE);
            r_sw       <= (w_state_nxt == ST_SAMPLE);
            r_sw_n     <= (w_state_nxt != ST_SAMPLE);
            r_en_c0_n  <= (w_state_nxt != ST_CONV);
            r_en_bit_n <= ~w_code_nxt[2:0];
            r_row_n    <= dec_row_n(w_code_nxt);
            r_rowon_n  <= dec_rowon_n(w_code_nxt);
            r_rowoff_n <= dec_rowoff_n(w_code_nxt);
            r_col      <= w_col_nxt;
            r_col_n    <= ~w_col_nxt;
        end
    end

    assign bus.sample   = r_sample;
    assign bus.sample_n = r_sample_n;
    assign bus.sw       = r_sw;
    assign bus.sw_n     = r_sw_n;
    assign bus.row_n    = r_row_n;
    assign bus.rowon_n  = r_rowon_n;
    assign bus.rowoff_n = r_rowoff_n;
    assign bus.col      = r_col;
    assign bus.col_n    = r_col_n;
    assign bus.en_bit_n = r_en_bit_n;
    assign bus.en_C0_n  = r_en_c0_n;
    assign bus.result   = r_result;
    assign bus.valid    = r_valid;
    assign bus.busy     = r_busy;

endmodule

// File: tb/tb_adc_sar_array_ctrl.sv
// Purpose : self-checking bench for adc_sar_array_ctrl (default timing and SETTLE_CYCLES=3).
// Latency : n/a.
// Backpressure: n/a.
module tb_adc_sar_array_ctrl;
    localparam int S = 4;
`ifdef SAR_NONOVL_EN
    localparam int H = 1;
`else
    localparam int H = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    adc_sar_array_ctrl_if if_a ();
    adc_sar_array_ctrl_if if_b ();

    adc_sar_array_ctrl #(.SAMPLE_CYCLES(4), .SETTLE_CYCLES(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a));
    adc_sar_array_ctrl #(.SAMPLE_CYCLES(4), .SETTLE_CYCLES(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b));

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int t0 = 0;
    int lat_seen = -1;
    bit sel = 1'b0;

    // Expected values for the current cycle, set by the stimulus process.
    bit          exp_chk = 1'b0;
    bit          exp_code_chk, exp_c0_chk;
    bit          exp_sample, exp_busy, exp_valid, exp_c0n;
    logic [11:0] exp_code, exp_result;
    logic [11:0] last_res [2];

    logic        obs_sample, obs_sample_n, obs_sw, obs_sw_n, obs_c0n, obs_valid, obs_busy;
    logic [15:0] obs_row_n, obs_rowon_n, obs_rowoff_n;
    logic [31:0] obs_col, obs_col_n;
    logic [2:0]  obs_en_bit_n;
    logic [11:0] obs_result;

    logic [15:0] first_row_n, first_rowon_n, first_rowoff_n, done_row_n, done_rowon_n, done_rowoff_n;
    logic [31:0] first_col, done_col;
    logic [2:0]  first_en_bit_n, done_en_bit_n;

    always_comb begin
        obs_sample   = sel ? if_b.sample   : if_a.sample;
        obs_sample_n = sel ? if_b.sample_n : if_a.sample_n;
        obs_sw       = sel ? if_b.sw       : if_a.sw;
        obs_sw_n     = sel ? if_b.sw_n     : if_a.sw_n;
        obs_c0n      = sel ? if_b.en_C0_n  : if_a.en_C0_n;
        obs_valid    = sel ? if_b.valid    : if_a.valid;
        obs_busy     = sel ? if_b.busy     : if_a.busy;
        obs_row_n    = sel ? if_b.row_n    : if_a.row_n;
        obs_rowon_n  = sel ? if_b.rowon_n  : if_a.rowon_n;
        obs_rowoff_n = sel ? if_b.rowoff_n : if_a.rowoff_n;
        obs_col      = sel ? if_b.col      : if_a.col;
        obs_col_n    = sel ? if_b.col_n    : if_a.col_n;
        obs_en_bit_n = sel ? if_b.en_bit_n : if_a.en_bit_n;
        obs_result   = sel ? if_b.result   : if_a.result;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference decode (plain arithmetic) ----------------
    function automatic logic [15:0] m_row_n(input logic [11:0] code);
        logic [31:0] v;
        v = 32'd1 << int'(code[11:8]);
        return ~v[15:0];
    endfunction
    function automatic logic [15:0] m_rowon_n(input logic [11:0] code);
        logic [31:0] v;
        v = (32'd1 << int'(code[11:8])) - 32'd1;
        return ~v[15:0];
    endfunction
    function automatic logic [15:0] m_rowoff_n(input logic [11:0] code);
        logic [31:0] v;
        v = 32'h0000FFFF << (int'(code[11:8]) + 1);
        return ~v[15:0];
    endfunction
    function automatic logic [31:0] m_col(input logic [11:0] code);
        logic [63:0] v;
        v = (64'd1 << int'(code[7:3])) - 64'd1;
        return v[31:0];
    endfunction
    function automatic bit inv_ok(input logic [15:0] a_n, input logic [15:0] b_n, input logic [15:0] c_n);
        logic [15:0] a, b, c;
        a = ~a_n; b = ~b_n; c = ~c_n;
        return ((a ^ b ^ c) == 16'hFFFF) && (((a & b) | (a & c) | (b & c)) == 16'h0);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, req, $time);
        end
    endtask

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        if (rst_n)
            chk("row_invariant", {31'b0, inv_ok(obs_row_n, obs_rowon_n, obs_rowoff_n)}, 32'd1);
        if (exp_chk) begin
            if (obs_valid && lat_seen < 0) lat_seen = cyc - t0;
            chk("sample",   {31'b0, obs_sample},   {31'b0, exp_sample});
            chk("sample_n", {31'b0, obs_sample_n}, {31'b0, !exp_sample});
            chk("sw",       {31'b0, obs_sw},       {31'b0, exp_sample});
            chk("sw_n",     {31'b0, obs_sw_n},     {31'b0, !exp_sample});
            chk("busy",     {31'b0, obs_busy},     {31'b0, exp_busy});
            chk("valid",    {31'b0, obs_valid},    {31'b0, exp_valid});
            chk("result",   {20'b0, obs_result},   {20'b0, exp_result});
            if (exp_c0_chk) chk("en_C0_n", {31'b0, obs_c0n}, {31'b0, exp_c0n});
            if (exp_code_chk) begin
                chk("row_n",    {16'b0, obs_row_n},    {16'b0, m_row_n(exp_code)});
                chk("rowon_n",  {16'b0, obs_rowon_n},  {16'b0, m_rowon_n(exp_code)});
                chk("rowoff_n", {16'b0, obs_rowoff_n}, {16'b0, m_rowoff_n(exp_code)});
                chk("col",      obs_col,   m_col(exp_code));
                chk("col_n",    obs_col_n, ~m_col(exp_code));
                chk("en_bit_n", {29'b0, obs_en_bit_n}, {29'b0, ~exp_code[2:0]});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_exp(input bit smp, input bit bsy, input bit vld, input bit code_chk,
                           input logic [11:0] code, input bit c0_chk, input bit c0n);
        exp_sample = smp; exp_busy = bsy; exp_valid = vld; exp_code_chk = code_chk;
        exp_code = code; exp_c0_chk = c0_chk; exp_c0n = c0n; exp_result = last_res[sel];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_start(input bit v);
        if (sel) if_b.start = v; else if_a.start = v;
    endtask

    task automatic drive_comp(input bit v);
        if (sel) if_b.comp_in = v; else if_a.comp_in = v;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            set_exp(0, 0, 0, 0, 12'h0, 0, 0);
        end
    endtask

    // One full conversion. Entered during an IDLE cycle of the chosen DUT;
    // returns inside the cycle where valid is high (also an IDLE cycle).
    task automatic conv(input bit use_b, input logic [11:0] vin, input bit ideal, input bit keep,
                        output logic [11:0] res_dut, output int lat);
        int          settle;
        logic [11:0] code, trial;
        bit          d;
        settle = use_b ? 3 : 1;
        d = 1'b0;
        if (sel != use_b) begin
            sel = use_b;
            set_exp(0, 0, 0, 0, 12'h0, 0, 0);
        end
        drive_start(1'b1);
        tick();
        t0 = cyc;
        lat_seen = -1;
        drive_start(keep);
        for (int i = 0; i < S; i++) begin
            set_exp(1, 1, 0, 1, 12'h0, 1, 1);
            drive_comp(1'($urandom));
            tick();
        end
        if (H != 0) begin
            set_exp(0, 1, 0, 1, 12'h0, 1, 1);
            tick();
        end
        code = 12'h0;
        for (int b = 11; b >= 0; b--) begin
            trial = code | (12'h1 << b);
            for (int s = 0; s < settle; s++) begin
                set_exp(0, 1, 0, 1, trial, 1, 0);
                if (!keep) drive_start(b == 8);
                if (b == 11 && s == 0) begin
                    first_row_n = obs_row_n; first_rowon_n = obs_rowon_n;
                    first_rowoff_n = obs_rowoff_n; first_col = obs_col; first_en_bit_n = obs_en_bit_n;
                end
                if (s == settle - 1) begin
                    d = ideal ? (vin >= trial) : 1'($urandom);
                    drive_comp(d);
                end else begin
                    drive_comp(1'($urandom));
                end
                tick();
            end
            if (d) code = trial;
        end
        drive_start(keep);
        set_exp(0, 1, 0, 1, code, 0, 0);
        done_row_n = obs_row_n; done_rowon_n = obs_rowon_n;
        done_rowoff_n = obs_rowoff_n; done_col = obs_col; done_en_bit_n = obs_en_bit_n;
        tick();
        last_res[sel] = code;
        set_exp(0, 0, 1, 0, 12'h0, 0, 0);
        drive_comp(1'b0);
        @(negedge clk);
        #1;
        chk("latency", lat_seen, S + H + 12 * settle + 1);
        res_dut = obs_result;
        lat = lat_seen;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_sample"},   {31'b0, if_a.sample},   32'd0);
        chk({tag, "_sample_n"}, {31'b0, if_a.sample_n}, 32'd1);
        chk({tag, "_sw"},       {31'b0, if_a.sw},       32'd0);
        chk({tag, "_sw_n"},     {31'b0, if_a.sw_n},     32'd1);
        chk({tag, "_en_C0_n"},  {31'b0, if_a.en_C0_n},  32'd1);
        chk({tag, "_en_bit_n"}, {29'b0, if_a.en_bit_n}, 32'd7);
        chk({tag, "_col"},      if_a.col,               32'h0);
        chk({tag, "_col_n"},    if_a.col_n,             32'hFFFFFFFF);
        chk({tag, "_row_n"},    {16'b0, if_a.row_n},    32'h0000FFFE);
        chk({tag, "_rowon_n"},  {16'b0, if_a.rowon_n},  32'h0000FFFF);
        chk({tag, "_rowoff_n"}, {16'b0, if_a.rowoff_n}, 32'h00000001);
        chk({tag, "_result"},   {20'b0, if_a.result},   32'h0);
        chk({tag, "_valid"},    {31'b0, if_a.valid},    32'd0);
        chk({tag, "_busy"},     {31'b0, if_a.busy},     32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [11:0] r, vin;
        int          lat;
        if_a.start = 1'b0; if_a.comp_in = 1'b0;
        if_b.start = 1'b0; if_b.comp_in = 1'b0;
        last_res[0] = 12'h0; last_res[1] = 12'h0;

        #2 rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check_reset("rst0");
        @(posedge clk); #1;
        rst_n = 1'b1;
        set_exp(0, 0, 0, 0, 12'h0, 0, 0);
        exp_chk = 1'b1;
        idle(2);

        // Ideal comparator, worked example.
        conv(0, 12'hA5C, 1, 0, r, lat);
        chk("a5c_result", {20'b0, r}, 32'h00000A5C);
        chk("a5c_latency", lat, 17 + H);
        chk("first_row_n",    {16'b0, first_row_n},    32'h0000FEFF);
        chk("first_rowon_n",  {16'b0, first_rowon_n},  32'h0000FF00);
        chk("first_rowoff_n", {16'b0, first_rowoff_n}, 32'h000001FF);
        chk("first_col",      first_col,               32'h0);
        chk("first_en_bit_n", {29'b0, first_en_bit_n}, 32'd7);

        // Boundary codes.
        idle(1);
        conv(0, 12'h000, 1, 0, r, lat);
        chk("zero_result", {20'b0, r}, 32'h0);
        conv(0, 12'hFFF, 1, 0, r, lat);
        chk("full_result", {20'b0, r}, 32'h00000FFF);
        chk("done_row_n",    {16'b0, done_row_n},    32'h00007FFF);
        chk("done_rowon_n",  {16'b0, done_rowon_n},  32'h00008000);
        chk("done_rowoff_n", {16'b0, done_rowoff_n}, 32'h0000FFFF);
        chk("done_col",      done_col,               32'h7FFFFFFF);
        chk("done_en_bit_n", {29'b0, done_en_bit_n}, 32'd0);

        // start held high: back-to-back with a single IDLE cycle.
        vin = 12'($urandom);
        conv(0, vin, 1, 1, r, lat);
        chk("keep1_result", {20'b0, r}, {20'b0, vin});
        vin = 12'($urandom);
        conv(0, vin, 1, 0, r, lat);
        chk("keep2_result", {20'b0, r}, {20'b0, vin});

        // Three-cycle settle, comp_in toggling on non-final cycles.
        idle(1);
        vin = 12'($urandom);
        conv(1, vin, 1, 0, r, lat);
        chk("settle3_result", {20'b0, r}, {20'b0, vin});
        chk("settle3_latency", lat, 41 + H);

        // Asynchronous reset while bit 6 is under trial.
        idle(1);
        if (sel) begin
            sel = 1'b0;
            set_exp(0, 0, 0, 0, 12'h0, 0, 0);
        end
        tick();
        exp_chk = 1'b0;
        drive_start(1'b1);
        drive_comp(1'b1);
        tick();
        drive_start(1'b0);
        repeat (S + H + 5) tick();
        chk("pre_rst_row_n", {16'b0, if_a.row_n}, 32'h00007FFF);
        chk("pre_rst_busy",  {31'b0, if_a.busy},  32'd1);
        #3 rst_n = 1'b0;
        #1 check_reset("rst_mid");
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive_comp(1'b0);
        last_res[0] = 12'h0; last_res[1] = 12'h0;
        set_exp(0, 0, 0, 0, 12'h0, 0, 0);
        exp_chk = 1'b1;
        idle(1);
        vin = 12'($urandom);
        conv(0, vin, 1, 0, r, lat);
        chk("post_rst_result", {20'b0, r}, {20'b0, vin});

        // Randomized conversions on either instance.
        for (int n = 0; n < 24; n++) begin
            bit use_b, ideal;
            use_b = ($urandom_range(0, 3) == 0);
            ideal = 1'($urandom);
            vin   = 12'($urandom);
            idle($urandom_range(0, 2));
            conv(use_b, vin, ideal, 0, r, lat);
            if (ideal) chk("rand_ideal_result", {20'b0, r}, {20'b0, vin});
        end

        idle(2);
        exp_chk = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc_sar_array_ctrl.md
Name: adc_sar_array_ctrl

Overview:
- SAR control engine directly upstream of the 12-bit capacitor array matrix; produces every digital control the matrix consumes.
- Runs sample → 12-step binary search → result, driven by the comparator decision on ctop.
- Code split: bits [11:3] form a 9-bit thermometer code (k) decoded onto the 16x32 unit-cell row/column lines. Bits [2:0] drive the binary en_bit_n caps.

Parameters:
- SAMPLE_CYCLES, 4, cycles that sample/sw stay asserted (legal range 1-255).
- SETTLE_CYCLES, 1, cycles per bit trial; comp_in is sampled on the last one (legal range 1-15).

Ports:
- clk  input  1  conversion clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request conversion; sampled only in IDLE
- comp_in  input  1  comparator decision: 1 = input above trial DAC level, keep bit
- sample  output  1  top-plate sample switch
- sample_n  output  1  complement of sample
- sw  output  1  bottom plates to vcm
- sw_n  output  1  complement of sw
- row_n  output  16  active-low, selects the partially filled row
- rowon_n  output  16  active-low, row fully on
- rowoff_n  output  16  active-low, row fully off
- col  output  32  active-high column enable within the partial row
- col_n  output  32  complement of col
- en_bit_n  output  3  active-low binary cap enables, = ~dac_code[2:0]
- en_C0_n  output  1  active-low C0 termination cap enable
- result  output  12  last completed conversion code
- valid  output  1  one-cycle pulse when result updates
- busy  output  1  high in any state except IDLE

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous, active-low. All outputs are registered.
- Reset (immediate, also mid-conversion): state = IDLE, dac_code = 0, result = 0, valid = 0, busy = 0.
- Reset output values: sample = 0, sample_n = 1, sw = 0, sw_n = 1, en_C0_n = 1, en_bit_n = 3'b111, col = 0, col_n = all ones.
- Reset row values (decode of code 0): row_n = 16'hFFFE, rowon_n = 16'hFFFF, rowoff_n = 16'h0001.
- Decode, from registered dac_code, with k = dac_code[11:3], r = k[8:5], c = k[4:0]:
  - row_n[i] = 0 iff i == r
  - rowon_n[i] = 0 iff i < r
  - rowoff_n[i] = 0 iff i > r
  - col[j] = 1 iff j < c; col_n = ~col
  - Invariant: exactly one of row_n/rowon_n/rowoff_n is low per row, every cycle.
- IDLE:
  - start = 1 → SAMPLE.
  - start is ignored in all other states.
- SAMPLE:
  - sample = sw = 1; dac_code = 0; en_C0_n = 1.
  - Lasts exactly SAMPLE_CYCLES cycles, then → CONV with bit index = 11 and dac_code = 12'h800.
- CONV:
  - sample = sw = 0; en_C0_n = 0.
  - Each trial holds dac_code for SETTLE_CYCLES cycles; comp_in is sampled at the clock edge ending the last one.
  - comp_in = 1: bit i kept. comp_in = 0: bit i cleared.
  - If i > 0, set bit i-1 for the next trial. After i = 0 → DONE.
- DONE (1 cycle):
  - result <= final code; valid = 1; dac_code holds the final code.
  - Next state → IDLE. The following conversion needs start high in IDLE, so back-to-back conversions have ≥1 IDLE cycle.
- busy = 1 in SAMPLE, CONV (and HOLD, when compiled in), DONE.
- Latency: valid rises SAMPLE_CYCLES + 12*SETTLE_CYCLES + 1 cycles after the edge that samples start (17 at defaults).
- Complement pairs (sample/sample_n, sw/sw_n, col/col_n) are driven from the same register edge; they are never equal.

Optional Feature:
- Macro: SAR_NONOVL_EN.
- Defined: a one-cycle HOLD state is inserted between SAMPLE and CONV.
  - In HOLD: sample = 0, sw = 0, dac_code = 0, en_C0_n = 1.
  - The top plate opens one cycle before the bottom plates leave vcm, giving break-before-make.
  - Latency grows by 1 (18 at defaults).
- Undefined: SAMPLE transitions directly to CONV.

Test Plan:
- Reset mid-CONV (rst_n low while bit 6 is under trial) → all outputs take reset values within the same cycle, with no clock edge. After release, start re-runs cleanly.
- Ideal comparator model, comp_in = (vin_code >= dac_code), with vin_code = 12'hA5C and defaults → valid pulses 17 cycles after start; result = 12'hA5C.
- First trial of any conversion → dac_code = 12'h800 with row_n = 16'hFEFF, rowon_n = 16'hFF00, rowoff_n = 16'h01FF, col = 0, en_bit_n = 3'b111.
- Boundary codes: vin_code = 12'h000 → result 12'h000. vin_code = 12'hFFF → result 12'hFFF, with the final DONE decode giving row_n = 16'h7FFF, rowon_n = 16'h8000, rowoff_n = 16'hFFFF, col = 32'h7FFFFFFF, en_bit_n = 3'b000.
- SETTLE_CYCLES = 3 with comp_in toggling during non-final settle cycles → only last-cycle samples affect the result; valid at 4 + 36 + 1 = 41 cycles.
- start held high continuously → conversions repeat with one IDLE cycle between DONE and SAMPLE. A start pulse during CONV is ignored (busy stays 1, no extra valid). With SAR_NONOVL_EN, sample = 0 and sw = 0 for exactly one cycle before the 12'h800 trial.
